// File: rtl/uart_pkg.sv
// Shared types and constants for the UART message sequencer.
// Holds the FSM encoding, the default byte width and the power-on message contents.
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } seq_state_t;

    localparam logic [7:0] MSG_DEF_0 = 8'hFF;
    localparam logic [7:0] MSG_DEF_1 = 8'h51;
    localparam logic [7:0] MSG_DEF_2 = 8'h55;
    localparam logic [7:0] MSG_DEF_3 = 8'h55;

    // Power-on content of buffer slot idx; slots past the canned message start at zero.
    function automatic logic [7:0] default_byte(input int idx);
        case (idx)
            0:       return MSG_DEF_0;
            1:       return MSG_DEF_1;
            2:       return MSG_DEF_2;
            3:       return MSG_DEF_3;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Clearable up-counter that flags when it sits at LIMIT; saturates there.
// Latency: at_limit is a compare on the registered count; no backpressure.
module seq_cycle_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] count;

    assign at_limit = (count == LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Streams the MSG_LEN-byte buffer to the UART transmitter on each start pulse.
// tx_wr one cycle after start; each byte waits for the tx_busy rise/fall handshake plus a gap.
module uart_msg_sequencer
    import uart_pkg::*;
#(
    parameter int  MSG_LEN     = 4,
    parameter int  DATA_W      = DATA_W_DEF,
    parameter int  GAP_CYCLES  = 16,
    parameter int  ACK_TIMEOUT = 1024,
    localparam int IDX_W       = $clog2(MSG_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              tx_busy,
    output logic              tx_wr,
    output logic [DATA_W-1:0] tx_data,
    output logic              seq_busy,
    output logic [IDX_W-1:0]  byte_idx,
    output logic              done,
    output logic              err
);

    localparam int ACK_W   = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W   = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam int GAP_LIM = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    seq_state_t        state;
    logic [DATA_W-1:0] buffer [MSG_LEN];

    logic ack_en, ack_hit;
    logic gap_en, gap_hit;

    // The ack window includes the ISSUE cycle so err lands exactly ACK_TIMEOUT cycles after tx_wr.
    assign ack_en   = (state == ISSUE) || (state == WAIT_ACK);
    assign gap_en   = (state == GAP);
    assign seq_busy = (state != IDLE);

    seq_cycle_counter #(
        .W     (ACK_W),
        .LIMIT (ACK_TIMEOUT - 1)
    ) u_ack_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (!ack_en),
        .en       (ack_en),
        .at_limit (ack_hit)
    );

    seq_cycle_counter #(
        .W     (GAP_W),
        .LIMIT (GAP_LIM)
    ) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (!gap_en),
        .en       (gap_en),
        .at_limit (gap_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx_wr    <= 1'b0;
            tx_data  <= '0;
            byte_idx <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) begin
                buffer[i] <= DATA_W'(default_byte(i));
            end
        end else begin
            tx_wr <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_en) begin
                        buffer[load_addr] <= load_data;
                    end
                    if (start) begin
                        state    <= ISSUE;
                        byte_idx <= '0;
                        tx_wr    <= 1'b1;
                        // Forward a same-cycle write to slot 0 so the fresh value goes out.
                        tx_data  <= (load_en && (load_addr == '0)) ? load_data : buffer[0];
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_hit) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (byte_idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_hit) begin
                        state   <= ISSUE;
                        tx_wr   <= 1'b1;
                        tx_data <= buffer[byte_idx];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Self-checking bench: vector table of messages, hand-written corner sequences and
// randomized messages checked against a byte-array model of the message buffer.
module tb_uart_msg_sequencer;

    localparam int MSG_LEN = 4;
    localparam int GAP     = 16;
    localparam int ACK     = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       load_en;
    logic [1:0] load_addr;
    logic [7:0] load_data;
    logic       tx_busy;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       seq_busy;
    logic [1:0] byte_idx;
    logic       done;
    logic       err;

    logic xmt_busy  = 1'b0;
    logic hold_busy = 1'b0;
    bit   xmt_en    = 1'b1;
    int   xmt_dly   = 2;
    int   xmt_hold  = 10;

    assign tx_busy = xmt_busy | hold_busy;

    uart_msg_sequencer #(
        .MSG_LEN     (MSG_LEN),
        .DATA_W      (8),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .tx_busy   (tx_busy),
        .tx_wr     (tx_wr),
        .tx_data   (tx_data),
        .seq_busy  (seq_busy),
        .byte_idx  (byte_idx),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int         wr_cyc [$];
    logic [7:0] wr_dat [$];
    logic [1:0] wr_idx [$];
    int         fall_cyc [$];
    int         done_cyc [$];
    int         err_cyc [$];
    int         wide_cnt;
    logic       prev_busy = 1'b0;
    logic       prev_wr   = 1'b0;

    logic [7:0] mbuf [MSG_LEN];

    typedef struct packed {
        logic [3:0]  ld_mask;
        logic [31:0] ld_dat;
        logic        sc_en;
        logic [1:0]  sc_addr;
        logic [7:0]  sc_dat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (tx_wr) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(tx_data);
            wr_idx.push_back(byte_idx);
            if (prev_wr) wide_cnt++;
        end
        if (prev_busy && !tx_busy) fall_cyc.push_back(cyc);
        if (done) done_cyc.push_back(cyc);
        if (err)  err_cyc.push_back(cyc);
        prev_busy = tx_busy;
        prev_wr   = tx_wr;
    end

    // Transmitter: busy rises xmt_dly cycles after a write strobe and stays up xmt_hold cycles.
    initial forever begin
        @(negedge clk);
        if (tx_wr && xmt_en) begin
            repeat (xmt_dly) @(posedge clk);
            #1 xmt_busy = 1'b1;
            repeat (xmt_hold) @(posedge clk);
            #1 xmt_busy = 1'b0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time exceeded, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        wr_cyc.delete(); wr_dat.delete(); wr_idx.delete();
        fall_cyc.delete(); done_cyc.delete(); err_cyc.delete();
        wide_cnt = 0;
    endtask

    task automatic model_reset();
        mbuf[0] = 8'hFF; mbuf[1] = 8'h51; mbuf[2] = 8'h55; mbuf[3] = 8'h55;
    endtask

    task automatic do_load(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = a; load_data = d;
        mbuf[a] = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic run_msg(input string tag, input int dly, input int hold,
                           input logic sc_en, input logic [1:0] sc_addr, input logic [7:0] sc_dat,
                           input bit spur, input bit use_model, input logic [31:0] exp);
        int          s_cyc;
        bit          fin;
        bit          spur_done;
        logic [31:0] exp_v;
        xmt_dly = dly; xmt_hold = hold; xmt_en = 1'b1;
        clear_q();
        @(posedge clk); #1;
        start = 1'b1; s_cyc = cyc;
        if (sc_en) begin
            load_en = 1'b1; load_addr = sc_addr; load_data = sc_dat;
            mbuf[sc_addr] = sc_dat;
        end
        for (int i = 0; i < MSG_LEN; i++) exp_v[8*i +: 8] = mbuf[i];
        if (!use_model) exp_v = exp;
        fin = 1'b0; spur_done = 1'b0;
        for (int k = 0; k < 800 && !fin; k++) begin
            @(posedge clk); #1;
            start = 1'b0; load_en = 1'b0;
            if (spur && !spur_done && wr_cyc.size() == 2) begin
                start = 1'b1; load_en = 1'b1; load_addr = 2'd2; load_data = 8'hAA;
                spur_done = 1'b1;
            end
            fin = (done_cyc.size() > 0) || (err_cyc.size() > 0);
        end
        check({tag, " finished"}, 32'(fin), 32'd1);
        repeat (20) @(posedge clk); #1;
        check({tag, " wr count"}, wr_cyc.size(), MSG_LEN);
        for (int i = 0; i < MSG_LEN && i < wr_cyc.size(); i++) begin
            check($sformatf("%s byte%0d data", tag, i), 32'(wr_dat[i]), 32'(exp_v[8*i +: 8]));
            check($sformatf("%s byte%0d idx", tag, i), 32'(wr_idx[i]), i);
            if (i == 0)
                check({tag, " first wr latency"}, wr_cyc[0], s_cyc + 1);
            else if (fall_cyc.size() >= i)
                check($sformatf("%s byte%0d gap", tag, i), wr_cyc[i], fall_cyc[i-1] + GAP + 1);
        end
        check({tag, " wide wr"}, wide_cnt, 0);
        check({tag, " done count"}, done_cyc.size(), 1);
        if (done_cyc.size() >= 1 && fall_cyc.size() >= MSG_LEN)
            check({tag, " done time"}, done_cyc[0], fall_cyc[MSG_LEN-1] + 1);
        check({tag, " err count"}, err_cyc.size(), 0);
        check({tag, " idle after"}, 32'(seq_busy), 32'd0);
    endtask

    initial begin
        int s_cyc;
        bit fin;

        vecs[0] = '{4'b0000, 32'h00000000, 1'b0, 2'd0, 8'h00, 32'h555551FF};
        vecs[1] = '{4'b1111, 32'h4F4C4548, 1'b0, 2'd0, 8'h00, 32'h4F4C4548};
        vecs[2] = '{4'b0000, 32'h00000000, 1'b1, 2'd0, 8'h3C, 32'h4F4C453C};
        vecs[3] = '{4'b0100, 32'h00000000, 1'b0, 2'd0, 8'h00, 32'h4F00453C};
        vecs[4] = '{4'b0010, 32'h00007E00, 1'b1, 2'd3, 8'hA5, 32'hA5007E3C};

        reset = 1'b0; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset tx_wr", 32'(tx_wr), 0);
        check("reset seq_busy", 32'(seq_busy), 0);
        check("reset byte_idx", 32'(byte_idx), 0);
        check("reset tx_data", 32'(tx_data), 0);
        check("reset done/err", 32'({done, err}), 0);
        @(posedge clk); #1 reset = 1'b1;

        // Start and load pulsed mid-message must neither queue nor touch byte 2.
        run_msg("ignored", 2, 10, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 32'h555551FF);

        for (int v = 0; v < 5; v++) begin
            for (int a = 0; a < MSG_LEN; a++)
                if (vecs[v].ld_mask[a]) do_load(2'(a), vecs[v].ld_dat[8*a +: 8]);
            run_msg($sformatf("vec%0d", v), 2, 10, vecs[v].sc_en, vecs[v].sc_addr,
                    vecs[v].sc_dat, 1'b0, 1'b0, vecs[v].exp);
        end

        // Reset while byte 1 is in flight.
        clear_q();
        xmt_en = 1'b1; xmt_dly = 2; xmt_hold = 10;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 200 && !fin; k++) begin
            @(posedge clk); #2;
            fin = (wr_cyc.size() == 2) && tx_busy;
        end
        check("midrst reached byte1", 32'(fin), 1);
        @(posedge clk); #2;
        check("midrst pre idx", 32'(byte_idx), 1);
        check("midrst pre busy", 32'(seq_busy), 1);
        reset = 1'b0;
        #1;
        check("midrst tx_wr", 32'(tx_wr), 0);
        check("midrst seq_busy", 32'(seq_busy), 0);
        check("midrst byte_idx", 32'(byte_idx), 0);
        model_reset();
        fin = 1'b0;
        for (int k = 0; k < 50 && !fin; k++) begin
            @(posedge clk);
            fin = !xmt_busy;
        end
        @(posedge clk); #1 reset = 1'b1;
        run_msg("postrst", 2, 10, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 32'h555551FF);

        // Transmitter never acknowledges.
        clear_q();
        xmt_en = 1'b0;
        @(posedge clk); #1 start = 1'b1; s_cyc = cyc;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < ACK + 100 && err_cyc.size() == 0; k++) @(posedge clk);
        repeat (30) @(posedge clk); #1;
        check("timeout err count", err_cyc.size(), 1);
        check("timeout wr count", wr_cyc.size(), 1);
        if (err_cyc.size() >= 1 && wr_cyc.size() >= 1)
            check("timeout err time", err_cyc[0], wr_cyc[0] + ACK);
        check("timeout done count", done_cyc.size(), 0);
        check("timeout idle", 32'(seq_busy), 0);

        // Busy already high when the byte is issued.
        clear_q();
        @(posedge clk); #1 hold_busy = 1'b1;
        @(posedge clk); #1 start = 1'b1; s_cyc = cyc;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 hold_busy = 1'b0; xmt_en = 1'b1; xmt_dly = 2; xmt_hold = 4;
        for (int k = 0; k < 400 && done_cyc.size() == 0 && err_cyc.size() == 0; k++) @(posedge clk);
        repeat (5) @(posedge clk); #1;
        check("level wr count", wr_cyc.size(), MSG_LEN);
        if (wr_cyc.size() >= 2 && fall_cyc.size() >= 1) begin
            check("level wr0 time", wr_cyc[0], s_cyc + 1);
            check("level wr1 time", wr_cyc[1], fall_cyc[0] + GAP + 1);
            check("level wr1 data", 32'(wr_dat[1]), 32'(mbuf[1]));
        end
        check("level done", done_cyc.size(), 1);
        check("level err", err_cyc.size(), 0);

        for (int r = 0; r < 6; r++) begin
            int n_ld;
            n_ld = $urandom_range(0, 3);
            for (int j = 0; j < n_ld; j++)
                do_load(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            run_msg($sformatf("rand%0d", r), $urandom_range(1, 4), $urandom_range(1, 12),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'b1, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
